// File: rtl/bitblade_pkg.sv
// Shared types and constants for the BitBlade brick datapath: precision modes,
// brick geometry and the per-brick shift rule.
package bitblade_pkg;

    localparam int PROD_W  = 6;
    localparam int NBRICK  = 16;
    localparam int BEAT_W  = 18;
    localparam int SHIFT_W = 4;

    typedef enum logic [1:0] {
        MODE_2B = 2'd0,
        MODE_4B = 2'd1,
        MODE_8B = 2'd2
    } mode_e;

    // The reserved encoding behaves exactly like 2b x 2b.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_2B : mode_e'(m);
    endfunction

    // Brick k = {k3,k2,k1,k0}; the shift is twice the sum of the digit weights.
    function automatic logic [SHIFT_W-1:0] brick_shift(input mode_e mode, input logic [3:0] k);
        logic [SHIFT_W-1:0] s;
        s = '0;
        case (mode)
            MODE_4B: s = ({3'b000, k[0]} + {3'b000, k[1]}) << 1;
            MODE_8B: s = ({2'b00, k[1:0]} + {2'b00, k[3:2]}) << 1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bitbrick_shift_accumulator_if.sv
// Beat input and result output handshake bundle of the shift accumulator.
interface bitbrick_shift_accumulator_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [95:0]             in_prod;
    logic [1:0]              in_mode;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_acc;
    logic [CNT_W-1:0]        out_cnt;
    logic                    out_ovf;

    modport master (
        output in_valid, in_prod, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );
endinterface

// File: rtl/bitbrick_shift_tree.sv
// Combinational brick reduction: sign-extend each 6-bit product, apply its
// precision shift and sum all sixteen into one 18-bit signed beat value.
module bitbrick_shift_tree
    import bitblade_pkg::*;
(
    input  logic [PROD_W*NBRICK-1:0]  prod,
    input  mode_e                     mode,
    output logic signed [BEAT_W-1:0]  sum
);

    logic signed [BEAT_W-1:0] term [NBRICK];
    logic signed [BEAT_W-1:0] lvl  [NBRICK];

    generate
        for (genvar gi = 0; gi < NBRICK; gi++) begin : g_brick
            logic signed [BEAT_W-1:0] ext;
            assign ext      = {{(BEAT_W-PROD_W){prod[gi*PROD_W+PROD_W-1]}}, prod[gi*PROD_W +: PROD_W]};
            assign term[gi] = ext <<< brick_shift(mode, 4'(gi));
        end
    endgenerate

    // Pairwise reduction; each level halves the live width in place.
    always_comb begin
        for (int i = 0; i < NBRICK; i++) begin
            lvl[i] = term[i];
        end
        for (int w = NBRICK / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                lvl[i] = lvl[2*i] + lvl[2*i+1];
            end
        end
        sum = lvl[0];
    end

endmodule

// File: rtl/bitbrick_shift_accumulator.sv
// Three-stage BitBlade accumulator: beat-sum register, group accumulator and
// output register, all stalled together behind the output handshake.
module bitbrick_shift_accumulator
    import bitblade_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    bitbrick_shift_accumulator_if.slave bus
);

    logic                     adv;
    logic                     in_fire;
    mode_e                    in_mode_n;
    mode_e                    eff_mode;
    logic signed [BEAT_W-1:0] beat_sum;

    logic        first_in_q, first_in_d;
    mode_e       grp_mode_q, grp_mode_d;

    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_last_q,  s1_last_d;
    logic                     s1_first_q, s1_first_d;
    logic signed [BEAT_W-1:0] s1_sum_q,   s1_sum_d;

    logic                     s2_valid_q, s2_valid_d;
    logic                     s2_last_q,  s2_last_d;
    logic [ACC_W-1:0]         acc_q,      acc_d;
    logic [CNT_W-1:0]         cnt_q,      cnt_d;
    logic                     ovf_q,      ovf_d;

    logic                     out_valid_q, out_valid_d;
    logic [ACC_W-1:0]         out_acc_q,   out_acc_d;
    logic [CNT_W-1:0]         out_cnt_q,   out_cnt_d;
    logic                     out_ovf_q,   out_ovf_d;

    logic [ACC_W-1:0]         beat_ext;
    logic [ACC_W-1:0]         acc_sum;
    logic                     add_ovf;

    assign adv       = !out_valid_q || bus.out_ready;
    assign in_fire   = bus.in_valid && adv;
    assign in_mode_n = norm_mode(bus.in_mode);
    // Later beats of a group reuse the mode captured on its first beat.
    assign eff_mode  = first_in_q ? in_mode_n : grp_mode_q;

    bitbrick_shift_tree u_tree (
        .prod (bus.in_prod),
        .mode (eff_mode),
        .sum  (beat_sum)
    );

    assign beat_ext = {{(ACC_W-BEAT_W){s1_sum_q[BEAT_W-1]}}, s1_sum_q};
    assign acc_sum  = acc_q + beat_ext;
    assign add_ovf  = (acc_q[ACC_W-1] == beat_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        first_in_d  = first_in_q;
        grp_mode_d  = grp_mode_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_first_d  = s1_first_q;
        s1_sum_d    = s1_sum_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;

        if (adv) begin
            if (in_fire) begin
                first_in_d = bus.in_last;
                grp_mode_d = eff_mode;
            end
            s1_valid_d = in_fire;
            s1_last_d  = bus.in_last;
            s1_first_d = first_in_q;
            s1_sum_d   = beat_sum;

            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            if (s1_valid_q) begin
                if (s1_first_q) begin
                    acc_d = beat_ext;
                    cnt_d = CNT_W'(1);
                    ovf_d = 1'b0;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_ovf;
                end
            end

            // Draining and reloading in one edge keeps out_valid high.
            out_valid_d = s2_valid_q && s2_last_q;
            if (s2_valid_q && s2_last_q) begin
                out_acc_d = acc_q;
                out_cnt_d = cnt_q;
                out_ovf_d = ovf_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_in_q  <= 1'b1;
            grp_mode_q  <= MODE_2B;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_first_q  <= 1'b1;
            s1_sum_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            first_in_q  <= first_in_d;
            grp_mode_q  <= grp_mode_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_first_q  <= s1_first_d;
            s1_sum_q    <= s1_sum_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bitbrick_shift_accumulator.sv
// Directed bench: a 32-bit and a 20-bit accumulator share one stimulus stream
// so wrap and overflow behaviour can be compared on identical beats.
module tb_bitbrick_shift_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [95:0] in_prod = '0;
    logic [1:0]  in_mode = 2'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitbrick_shift_accumulator_if #(.ACC_W(32), .CNT_W(8)) a_if ();
    bitbrick_shift_accumulator_if #(.ACC_W(20), .CNT_W(8)) b_if ();

    assign a_if.in_valid  = in_valid;
    assign a_if.in_prod   = in_prod;
    assign a_if.in_mode   = in_mode;
    assign a_if.in_last   = in_last;
    assign a_if.out_ready = out_ready;
    assign b_if.in_valid  = in_valid;
    assign b_if.in_prod   = in_prod;
    assign b_if.in_mode   = in_mode;
    assign b_if.in_last   = in_last;
    assign b_if.out_ready = out_ready;

    bitbrick_shift_accumulator #(.ACC_W(32), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    bitbrick_shift_accumulator #(.ACC_W(20), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct packed {
        logic signed [31:0] acc;
        logic [7:0]         cnt;
        logic               ovf;
    } res_t;

    res_t qa[$];
    res_t qb[$];

    always @(posedge clk) begin
        if (!rst && a_if.out_valid && a_if.out_ready)
            qa.push_back({a_if.out_acc, a_if.out_cnt, a_if.out_ovf});
        if (!rst && b_if.out_valid && b_if.out_ready)
            qb.push_back({{12{b_if.out_acc[19]}}, b_if.out_acc, b_if.out_cnt, b_if.out_ovf});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns 1 time unit after the accepting edge.
    task automatic send(input logic [95:0] p, input logic [1:0] m, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_mode  = m;
        in_last  = l;
        #1;
        while (!a_if.in_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("send_accept", longint'(a_if.in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input string tag, input longint acc_a, input longint acc_b,
                              input longint cnt, input longint ovf_a, input longint ovf_b);
        int   n;
        res_t ra;
        res_t rb;
        n = 0;
        while ((qa.size() == 0 || qb.size() == 0) && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_avail"}, longint'(qa.size() > 0 && qb.size() > 0), 1);
        ra = (qa.size() > 0) ? qa.pop_front() : '0;
        rb = (qb.size() > 0) ? qb.pop_front() : '0;
        chk({tag, "_acc_a"}, longint'(ra.acc), acc_a);
        chk({tag, "_acc_b"}, longint'(rb.acc), acc_b);
        chk({tag, "_cnt"},   longint'(ra.cnt), cnt);
        chk({tag, "_ovf_a"}, longint'(ra.ovf), ovf_a);
        chk({tag, "_ovf_b"}, longint'(rb.ovf), ovf_b);
    endtask

    logic [95:0] p_ones;
    logic [95:0] p_nine;
    logic [95:0] p_m128;
    logic [95:0] p_seven;

    initial begin
        p_ones  = {16{6'd1}};
        p_nine  = {16{6'd9}};
        p_m128  = {6'd4, 90'd0};
        p_seven = 96'd7;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", longint'(a_if.out_valid), 0);
        chk("rst_out_acc",   longint'(a_if.out_acc), 0);
        chk("rst_out_cnt",   longint'(a_if.out_cnt), 0);
        chk("rst_out_ovf",   longint'(a_if.out_ovf), 0);
        chk("rst_in_ready",  longint'(a_if.in_ready), 1);
        rst = 1'b0;
        tick();

        // Mode 0 single beat: latency of exactly two edges after accept
        send(p_ones, 2'd0, 1'b1);
        chk("lat_edge0_valid", longint'(a_if.out_valid), 0);
        tick();
        chk("lat_edge1_valid", longint'(a_if.out_valid), 0);
        tick();
        chk("lat_edge2_valid", longint'(a_if.out_valid), 1);
        chk("lat_acc",         longint'($signed(a_if.out_acc)), 16);
        chk("lat_cnt",         longint'(a_if.out_cnt), 1);
        chk("lat_ovf",         longint'(a_if.out_ovf), 0);
        expect_res("m0_ones", 16, 16, 1, 0, 0);

        // Mode 2: 255x255 unsigned and -128x-128 signed
        send(p_nine, 2'd2, 1'b1);
        expect_res("m2_255", 65025, 65025, 1, 0, 0);
        send(p_m128, 2'd2, 1'b1);
        expect_res("m2_m128", 16384, 16384, 1, 0, 0);

        // Mode 1 four-beat group; mode change on beat 3 must be ignored
        send(p_nine, 2'd1, 1'b0);
        send(p_nine, 2'd1, 1'b0);
        send(p_nine, 2'd2, 1'b0);
        send(p_nine, 2'd1, 1'b1);
        expect_res("m1_group", 3600, 3600, 4, 0, 0);

        // Back-pressure: results pending while out_ready is low
        out_ready = 1'b0;
        send(p_ones,  2'd0, 1'b1);
        send(p_seven, 2'd0, 1'b1);
        send(p_nine,  2'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready",  longint'(a_if.in_ready), 0);
            chk("stall_out_valid", longint'(a_if.out_valid), 1);
            chk("stall_out_acc",   longint'($signed(a_if.out_acc)), 16);
            tick();
        end
        chk("stall_no_drain", longint'(qa.size()), 0);
        out_ready = 1'b1;
        send(p_m128, 2'd2, 1'b1);
        expect_res("drain_1", 16, 16, 1, 0, 0);
        expect_res("drain_2", 7, 7, 1, 0, 0);
        expect_res("drain_3", 65025, 65025, 1, 0, 0);
        expect_res("drain_4", 16384, 16384, 1, 0, 0);

        // Nine beats of 65025: 585225 fits in 32 bits, wraps in 20 bits
        for (int i = 0; i < 9; i++) begin
            send(p_nine, 2'd2, (i == 8) ? 1'b1 : 1'b0);
        end
        expect_res("wrap", 585225, -463351, 9, 0, 1);
        send(p_ones, 2'd0, 1'b1);
        expect_res("after_wrap", 16, 16, 1, 0, 0);

        // Reset on beat 2 of a group discards it entirely
        send(p_ones, 2'd0, 1'b0);
        in_valid = 1'b1;
        in_prod  = p_ones;
        in_mode  = 2'd0;
        in_last  = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rstmid_out_valid", longint'(a_if.out_valid), 0);
            tick();
        end
        chk("rstmid_no_result", longint'(qa.size()), 0);
        send(p_seven, 2'd0, 1'b1);
        expect_res("rstmid_seven", 7, 7, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
